// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and an external memory.
// One outstanding request; address/controls held until gnt is sampled.
//   req, we     : access request / write enable (unit -> memory)
//   addr        : word-aligned byte address
//   be          : byte lanes, bit 3 = bits [31:24] = byte offset 0
//   wdata       : lane-positioned store data
//   gnt, rvalid : request accepted / read data valid (memory -> unit)
//   rdata       : read data
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: owns the GPR file, forms EA = (RA|0) + sext(D),
// performs one big-endian access per op over the memory bus, with update
// forms, alignment checking and a request/response timeout.
//   clock, reset           : rising-edge clock, synchronous active-low reset
//   start/op/update/rt/ra/disp : op request, taken only when idle
//   busy, done, err        : op in flight, completion pulse, abort flag
//   mem                    : memory bus (master side)
//   dbg_*                  : debug GPR write (idle only) and combinational read
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start, debug writes allowed
//   EXEC  | compute EA, check legality, set up bus fields
//   REQ   | mem request asserted until gnt (or timeout)
//   RESP  | load waiting for rvalid (or timeout)
//   FIN   | done pulse, err valid
module load_store_unit #(
   parameter int NREGS       = 32,
   parameter int MEM_TIMEOUT = 16,
   localparam int RW         = $clog2(NREGS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic                     update,
   input  logic [RW-1:0]            rt,
   input  logic [RW-1:0]            ra,
   input  logic [15:0]              disp,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   load_store_unit_if.master        mem,
   input  logic                     dbg_we,
   input  logic [RW-1:0]            dbg_addr,
   input  logic [31:0]              dbg_wdata,
   output logic [31:0]              dbg_rdata
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [2:0] OP_LWZ = 3'b000;
   localparam logic [2:0] OP_LHZ = 3'b001;
   localparam logic [2:0] OP_LHA = 3'b010;
   localparam logic [2:0] OP_LBZ = 3'b011;
   localparam logic [2:0] OP_STW = 3'b100;
   localparam logic [2:0] OP_STH = 3'b101;
   localparam logic [2:0] OP_STB = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_REQ, S_RESP, S_FIN} state_t;
   state_t state_q, state_d;

   logic [31:0]   gpr [NREGS];
   logic [2:0]    op_q;
   logic          upd_q;
   logic [RW-1:0] rt_q, ra_q;
   logic [15:0]   disp_q;
   logic [31:0]   base_q, ea_q;
   logic          err_q;
   logic [TW-1:0] cnt_q;
   logic          we_q;
   logic [31:0]   addr_q, wdata_q;
   logic [3:0]    be_q;

   logic          is_load, is_word, is_half, is_byte;
   logic [31:0]   ea, st_val, lane_wd, ld_val;
   logic [3:0]    lane_be;
   logic          exec_err, timeout;
   logic [15:0]   ld_half;
   logic [7:0]    ld_byte;

   assign is_load = ~op_q[2];
   assign is_word = (op_q == OP_LWZ) || (op_q == OP_STW);
   assign is_half = (op_q == OP_LHZ) || (op_q == OP_LHA) || (op_q == OP_STH);
   assign is_byte = (op_q == OP_LBZ) || (op_q == OP_STB);

   assign ea      = base_q + {{16{disp_q[15]}}, disp_q};
   assign st_val  = gpr[rt_q];
   assign timeout = (cnt_q == TW'(MEM_TIMEOUT - 1));

   assign exec_err = (op_q == OP_RSV)
                   | (upd_q & (ra_q == '0))
                   | (upd_q & is_load & (ra_q == rt_q))
                   | (is_half & ea[0])
                   | (is_word & (ea[1:0] != 2'b00));

   always_comb begin
      lane_be = 4'b1111;
      lane_wd = st_val;
      if (is_half) begin
         lane_be = ea[1] ? 4'b0011 : 4'b1100;
         lane_wd = {2{st_val[15:0]}};
      end else if (is_byte) begin
         lane_be = 4'b1000 >> ea[1:0];
         lane_wd = {4{st_val[7:0]}};
      end
   end

   always_comb begin
      ld_half = ea_q[1] ? mem.rdata[15:0] : mem.rdata[31:16];
      ld_byte = mem.rdata[31:24];
      case (ea_q[1:0])
         2'd1:    ld_byte = mem.rdata[23:16];
         2'd2:    ld_byte = mem.rdata[15:8];
         2'd3:    ld_byte = mem.rdata[7:0];
         default: ld_byte = mem.rdata[31:24];
      endcase
      case (op_q)
         OP_LHZ:  ld_val = {16'h0000, ld_half};
         OP_LHA:  ld_val = {{16{ld_half[15]}}, ld_half};
         OP_LBZ:  ld_val = {24'h000000, ld_byte};
         default: ld_val = mem.rdata;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_EXEC;
         S_EXEC: state_d = exec_err ? S_FIN : S_REQ;
         S_REQ: begin
            if (mem.gnt)      state_d = is_load ? S_RESP : S_FIN;
            else if (timeout) state_d = S_FIN;
         end
         S_RESP: if (mem.rvalid || timeout) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         op_q    <= '0;
         upd_q   <= 1'b0;
         rt_q    <= '0;
         ra_q    <= '0;
         disp_q  <= '0;
         base_q  <= '0;
         ea_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (dbg_we) gpr[dbg_addr] <= dbg_wdata;
               if (start) begin
                  op_q   <= op;
                  upd_q  <= update;
                  rt_q   <= rt;
                  ra_q   <= ra;
                  disp_q <= disp;
                  // ra=0 as a base reads as zero; GPR0 is otherwise ordinary
                  base_q <= (ra == '0) ? '0 : gpr[ra];
                  err_q  <= 1'b0;
               end
            end
            S_EXEC: begin
               ea_q  <= ea;
               err_q <= exec_err;
               cnt_q <= '0;
               if (!exec_err) begin
                  addr_q  <= {ea[31:2], 2'b00};
                  be_q    <= lane_be;
                  wdata_q <= lane_wd;
                  we_q    <= ~is_load;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + TW'(1);
               if (mem.gnt) begin
                  if (!is_load && upd_q) gpr[ra_q] <= ea_q;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end
            end
            S_RESP: begin
               cnt_q <= cnt_q + TW'(1);
               if (mem.rvalid) begin
                  gpr[rt_q] <= ld_val;
                  // ra==rt is rejected in EXEC, so these never collide
                  if (upd_q) gpr[ra_q] <= ea_q;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign err       = (state_q == S_FIN) & err_q;
   assign mem.req   = (state_q == S_REQ);
   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.be    = be_q;
   assign mem.wdata = wdata_q;
   assign dbg_rdata = gpr[dbg_addr];
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic        update = 1'b0;
   logic [4:0]  rt = '0, ra = '0;
   logic [15:0] disp = '0;
   logic        busy, done, err;
   logic        dbg_we = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic [31:0] dbg_rdata;

   load_store_unit_if bus();

   load_store_unit #(.NREGS(32), .MEM_TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .update(update),
      .rt(rt), .ra(ra), .disp(disp), .busy(busy), .done(done), .err(err),
      .mem(bus), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata)
   );

   always #5 clock = ~clock;

   // memory model
   logic [31:0] mem_arr [256];
   logic        gnt_en = 1'b1;
   logic        rv_en = 1'b1;
   int          gnt_wait = 0;
   int          stall = 0;
   logic        pend = 1'b0;

   assign bus.gnt    = bus.req && gnt_en && (stall >= gnt_wait);
   assign bus.rvalid = pend && rv_en;

   always @(posedge clock) begin
      if (!reset) begin
         pend  <= 1'b0;
         stall <= 0;
      end else begin
         if (bus.req && !bus.gnt) stall <= stall + 1;
         else                     stall <= 0;
         if (bus.req && bus.gnt && !bus.we) begin
            pend      <= 1'b1;
            bus.rdata <= mem_arr[bus.addr[9:2]];
         end else if (pend && rv_en) begin
            pend <= 1'b0;
         end
      end
   end

   // request monitor
   int          req_cycles = 0;
   logic [31:0] l_addr = '0, l_wdata = '0;
   logic [3:0]  l_be = '0;
   logic        l_we = 1'b0;
   always @(posedge clock) begin
      if (bus.req) begin
         req_cycles <= req_cycles + 1;
         l_addr     <= bus.addr;
         l_be       <= bus.be;
         l_we       <= bus.we;
         l_wdata    <= bus.wdata;
      end
   end

   typedef struct {
      logic e;
      int   lat;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int last_reqs = 0;
   logic [31:0] model [32];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      tick();
      dbg_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] expv);
      dbg_addr = a;
      #1;
      chk(tag, dbg_rdata, expv);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic u,
                         input logic [4:0] t, input logic [4:0] a, input logic [15:0] d,
                         input logic e_err, input int e_lat,
                         input logic chk_rt, input logic [31:0] rt_val);
      exp_t x;
      int n;
      int rc0;
      x.e = e_err; x.lat = e_lat;
      sb.push_back(x);
      rc0 = req_cycles;
      op = o; update = u; rt = t; ra = a; disp = d; dbg_addr = t;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      x = sb.pop_front();
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_lat"}, n, x.lat);
      chk({tag, "_err"}, err, x.e);
      if (chk_rt) chk({tag, "_rt"}, dbg_rdata, rt_val);
      last_reqs = req_cycles - rc0;
      tick();
      chk({tag, "_done_low"}, done, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      mem_arr[8'h41] = 32'h8899AABB;
      mem_arr[8'h3F] = 32'hCAFEF00D;

      // reset state
      reset = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_req", bus.req, 1'b0);
      chk("rst_we", bus.we, 1'b0);
      chk("rst_addr", bus.addr, 32'h0);
      chk("rst_be", {28'h0, bus.be}, 32'h0);
      chk("rst_wdata", bus.wdata, 32'h0);
      reset = 1'b1;
      tick();
      rd_chk("rst_gpr3", 5'd3, 32'h0);

      dbg_write(5'd3, 32'h100);
      rd_chk("dbg_gpr3", 5'd3, 32'h100);

      run_op("lwz", 3'b000, 1'b0, 5'd5, 5'd3, 16'd4, 1'b0, 4, 1'b1, 32'h8899AABB);
      chk("lwz_addr", l_addr, 32'h104);
      chk("lwz_be", {28'h0, l_be}, 32'hF);
      chk("lwz_we", l_we, 1'b0);
      chk("lwz_reqs", last_reqs, 1);

      run_op("lha", 3'b010, 1'b0, 5'd6, 5'd3, 16'd6, 1'b0, 4, 1'b1, 32'hFFFFAABB);
      chk("lha_be", {28'h0, l_be}, 32'h3);

      run_op("lbz", 3'b011, 1'b0, 5'd7, 5'd3, 16'd5, 1'b0, 4, 1'b1, 32'h00000099);
      chk("lbz_be", {28'h0, l_be}, 32'h4);

      run_op("lbz_ra0", 3'b011, 1'b0, 5'd8, 5'd0, 16'h0105, 1'b0, 4, 1'b1, 32'h00000099);
      chk("lbz_ra0_addr", l_addr, 32'h104);

      gnt_wait = 2;
      run_op("lwz_stall", 3'b000, 1'b0, 5'd11, 5'd3, 16'hFFFC, 1'b0, 6, 1'b1, 32'hCAFEF00D);
      chk("lwz_stall_addr", l_addr, 32'h0FC);
      chk("lwz_stall_reqs", last_reqs, 3);
      gnt_wait = 0;

      dbg_write(5'd4, 32'h12345678);
      run_op("stb_u", 3'b110, 1'b1, 5'd4, 5'd3, 16'd7, 1'b0, 3, 1'b0, 32'h0);
      chk("stb_be", {28'h0, l_be}, 32'h1);
      chk("stb_we", l_we, 1'b1);
      chk("stb_lane", {24'h0, l_wdata[7:0]}, 32'h78);
      chk("stb_addr", l_addr, 32'h104);
      chk("stb_reqs", last_reqs, 1);
      rd_chk("stb_gpr3", 5'd3, 32'h107);

      run_op("misalign", 3'b000, 1'b0, 5'd12, 5'd3, 16'd2, 1'b1, 2, 1'b1, 32'h0);
      chk("misalign_reqs", last_reqs, 0);
      run_op("rsv", 3'b111, 1'b0, 5'd12, 5'd3, 16'd1, 1'b1, 2, 1'b1, 32'h0);
      chk("rsv_reqs", last_reqs, 0);
      run_op("upd_ra_rt", 3'b000, 1'b1, 5'd3, 5'd3, 16'd1, 1'b1, 2, 1'b0, 32'h0);
      chk("upd_ra_rt_reqs", last_reqs, 0);
      run_op("upd_ra0", 3'b100, 1'b1, 5'd4, 5'd0, 16'd0, 1'b1, 2, 1'b0, 32'h0);
      chk("upd_ra0_reqs", last_reqs, 0);
      rd_chk("err_gpr3", 5'd3, 32'h107);
      rd_chk("err_gpr4", 5'd4, 32'h12345678);

      gnt_en = 1'b0;
      run_op("timeout", 3'b000, 1'b0, 5'd9, 5'd3, 16'd1, 1'b1, 18, 1'b1, 32'h0);
      chk("timeout_reqs", last_reqs, 16);
      chk("timeout_req_low", bus.req, 1'b0);
      rd_chk("timeout_gpr3", 5'd3, 32'h107);
      gnt_en = 1'b1;

      // reset while a load waits in RESP
      rv_en = 1'b0;
      op = 3'b000; update = 1'b0; rt = 5'd10; ra = 5'd3; disp = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("resp_busy", busy, 1'b1);
      chk("resp_req", bus.req, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      rv_en = 1'b1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_req", bus.req, 1'b0);
      for (int i = 0; i < 32; i++) rd_chk("mid_rst_gpr", 5'(i), 32'h0);
      tick();
      chk("mid_rst_done2", done, 1'b0);

      run_op("recover", 3'b000, 1'b0, 5'd5, 5'd0, 16'h0104, 1'b0, 4, 1'b1, 32'h8899AABB);
      model[5] = 32'h8899AABB;
      for (int i = 0; i < 32; i++) rd_chk("final_gpr", 5'(i), model[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised multi-cycle load/store execution unit for the uPower datapath. Owns the GPR file, computes effective addresses as (RA|0) + sign-extended D, and issues one big-endian access at a time to an external data memory through a req/gnt/rvalid handshake. Supports word, halfword and byte loads (zero- and sign-extending) and stores, update forms, alignment checking and a memory timeout.

## Interface
- NREGS, 32, number of GPRs (power of two, 8..32); RW = $clog2(NREGS)
- MEM_TIMEOUT, 16, max cycles spent in REQ+RESP before abort (>=2)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request op; accepted only when busy=0
- op  in  3  000 lwz, 001 lhz, 010 lha, 011 lbz, 100 stw, 101 sth, 110 stb, 111 reserved
- update  in  1  write EA back to RA
- rt, ra  in  RW  target/source register, base register
- disp  in  16  signed displacement D
- busy  out  1  op in flight
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = op aborted, no architectural writes
- mem_req, mem_we  out  1  access request, write enable
- mem_addr  out  32  word-aligned byte address (EA & ~3)
- mem_be  out  4  byte lanes; bit 3 = bits[31:24] = byte offset 0
- mem_wdata  out  32  lane-positioned store data
- mem_gnt, mem_rvalid  in  1  request accepted, read data valid
- mem_rdata  in  32  read data
- dbg_we  in  1  debug GPR write, honoured only when busy=0
- dbg_addr  in  RW  debug read/write index
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  combinational GPR[dbg_addr]

## Operation
- States: IDLE, EXEC, REQ, RESP, FIN.
- IDLE: start=1 latches op/update/rt/ra/disp and GPR[ra] -> EXEC; busy=1 from next cycle. start while busy ignored.
- EXEC: EA = (ra==0 ? 0 : GPR[ra]) + sext(disp), modulo 2^32. Error if op=111; update with ra==0; update load with ra==rt; halfword with EA[0]=1; word with EA[1:0]!=0. Error -> FIN (err=1), else -> REQ.
- REQ: mem_req=1; addr/we/be/wdata held stable until mem_gnt=1 sampled. Store + gnt -> FIN. Load + gnt -> RESP.
- Lanes (big-endian): word be=1111; half be=1100 (EA[1]=0) or 0011; byte be=1000>>EA[1:0]. Store data replicated into selected lanes. Loads use be=lane mask, mem_we=0.
- RESP: on mem_rvalid extract lanes; lhz/lbz zero-extend, lha sign-extends; write GPR[rt]; update writes GPR[ra]=EA same edge -> FIN.
- Store update writes GPR[ra]=EA on the gnt edge.
- Timeout: counter clears on entering REQ, increments each REQ/RESP cycle; reaching MEM_TIMEOUT -> FIN with err=1, no GPR writes, mem_req drops.
- FIN: done=1, err per flags -> IDLE.
- GPR0 is real storage (writable as rt); only as base does ra=0 read as 0.
- Debug write while busy=1 ignored; dbg_rdata reflects writes from the next cycle.

## Timing
- Reset (reset=0 at rising edge): state IDLE, all GPRs 0, counter 0; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata = 0.
- Reset mid-operation: op abandoned, no done, no GPR writes; mem_req low after that edge.
- Zero-wait memory (gnt in first REQ cycle, rvalid in first RESP cycle): load done 4 cycles after start edge, GPR[rt] visible on dbg_rdata in the done cycle; store done 3 cycles after; error from EXEC done 2 cycles after.
- Each gnt stall or rvalid wait adds one cycle.
- mem_req is never asserted outside REQ; exactly one request per non-error op.
- done never asserted on consecutive cycles; next start accepted in the cycle after done.

## Test plan
- dbg-write GPR3=0x100, mem word @0x104=0x8899AABB; lwz rt=5 ra=3 D=4, zero-wait -> mem_addr=0x104, be=1111, done at +4, GPR5=0x8899AABB, err=0.
- Same memory; lha rt=6 ra=3 D=6 -> be=0011, GPR6=0xFFFFAABB; lbz rt=7 D=5 -> be=0100, GPR7=0x00000099.
- GPR3=0x100, GPR4=0x12345678; stb rt=4 ra=3 D=7 update=1 -> be=0001, wdata lane[7:0]=0x78, we=1, GPR3=0x107, done at +3.
- lwz ra=3 D=2 (misaligned) -> no mem_req, done at +2 with err=1, GPRs unchanged; repeat with op=111 and update-load ra=rt -> same.
- mem_gnt tied 0, MEM_TIMEOUT=16 -> mem_req held 16 cycles then dropped, done with err=1, no writes.
- reset low during RESP of a load -> busy=0, no done, GPRs all 0 after the edge; start afterwards completes normally.
